// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains a registered-read FIFO and packs LANES entries
// into one wide word on a valid/ready output, with partial-word flush.
module fifo_rd_packer #(
   parameter int WIDTH = 8,
   parameter int LANES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   i_empty,
   output logic                   o_rd,
   input  logic [WIDTH-1:0]       i_rddata,
   input  logic                   i_flush,
   output logic                   o_valid,
   input  logic                   i_ready,
   output logic [WIDTH*LANES-1:0] o_data,
   output logic [LANES-1:0]       o_keep
);

   localparam int IW = $clog2(LANES);
   localparam int CW = IW + 1;
   localparam logic [CW-1:0] FULL = CW'(LANES);
   localparam logic [CW:0] LANES_W = (CW+1)'(LANES);

   logic [LANES-1:0][WIDTH-1:0] acc_q, acc_d;
   logic [LANES-1:0][WIDTH-1:0] data_q, data_d;
   logic [LANES-1:0]            keep_q, keep_d;
   logic [CW-1:0]               cnt_q, cnt_d, eff_cnt;
   logic                        valid_q, valid_d;
   logic                        pend_q, pend_d;
   logic                        flush_q, flush_d;
   logic                        flush_go, xfer, rd;

   // eff_cnt lets a pop issue in the same cycle the accumulator empties
   always_comb begin
      flush_go = flush_q && !pend_q && (cnt_q != '0);
      xfer     = ((cnt_q == FULL) || flush_go) && (!valid_q || i_ready);
      eff_cnt  = xfer ? '0 : cnt_q;
      rd       = !reset && !i_empty && !flush_q &&
                 (({1'b0, eff_cnt} + (CW+1)'(pend_q)) < LANES_W);
   end

   always_comb begin
      acc_d   = acc_q;
      data_d  = data_q;
      keep_d  = keep_q;
      valid_d = valid_q;
      cnt_d   = eff_cnt;
      pend_d  = rd;
      flush_d = flush_q;
      if (xfer) begin
         valid_d = 1'b1;
         for (int k = 0; k < LANES; k++) begin
            keep_d[k] = CW'(k) < cnt_q;
            data_d[k] = keep_d[k] ? acc_q[k] : '0;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end
      if (pend_q) begin
         acc_d[eff_cnt[IW-1:0]] = i_rddata;
         cnt_d = eff_cnt + 1'b1;
      end
      // a flush with nothing held or in flight retires silently
      if (flush_q) begin
         if ((xfer && flush_go) || (cnt_q == '0 && !pend_q)) begin
            flush_d = 1'b0;
         end
      end else if (i_flush) begin
         flush_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q   <= '0;
         data_q  <= '0;
         keep_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         flush_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         data_q  <= data_d;
         keep_q  <= keep_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         flush_q <= flush_d;
      end
   end

   assign o_rd    = rd;
   assign o_valid = valid_q;
   assign o_data  = data_q;
   assign o_keep  = keep_q;

endmodule

// File: doc/fifo_rd_packer.md
# fifo_rd_packer

Read-side drain stage placed directly downstream of the synchronous byte FIFO. It pops `WIDTH`-bit entries whenever the FIFO is non-empty and space is guaranteed, accounting for the FIFO's one-cycle registered read latency. It packs `LANES` consecutive entries into one wide word and presents that word on a valid/ready output with full backpressure. A flush request emits a partially filled word with a lane-keep mask.

## Interface

**Parameters**
- `WIDTH`, default 8: FIFO entry width in bits.
- `LANES`, default 4: entries per output word. Power of two, at least 2.

**Ports**
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `i_empty`, input, 1: FIFO empty flag.
- `o_rd`, output, 1: FIFO read strobe. Combinational.
- `i_rddata`, input, `WIDTH`: FIFO read data. Valid the cycle after an accepted `o_rd`.
- `i_flush`, input, 1: single-cycle request to emit a partial word.
- `o_valid`, output, 1: output word valid.
- `i_ready`, input, 1: downstream accepts the word.
- `o_data`, output, `WIDTH*LANES`: packed word. Lane 0 is in `[WIDTH-1:0]` and holds the oldest entry.
- `o_keep`, output, `LANES`: bit k set means lane k holds real data.

## Operation

**Internal state**
- `acc[LANES]`: accumulator of `WIDTH`-bit lanes.
- `acc_cnt`: 0..`LANES`.
- `pend`: 1 bit, a pop was issued last cycle.
- `flush_req`: 1 bit.
- Output register: `o_data`, `o_keep`, `o_valid`.

**Transfer**
- `xfer = (acc_cnt==LANES || flush_go) && (!o_valid || i_ready)`.
- `flush_go = flush_req && !pend && acc_cnt!=0`.
- On `xfer`:
  - `o_data` receives `acc`, with unfilled lanes forced to 0.
  - `o_keep` receives `(1<<acc_cnt)-1`.
  - `o_valid` is set to 1.
  - `acc_cnt` is cleared.
- If `o_valid && i_ready` and no `xfer` occurs, `o_valid` is cleared. `o_data` and `o_keep` keep their values.

**Pop rule**
- `eff_cnt = xfer ? 0 : acc_cnt`.
- `o_rd = !reset && !i_empty && !flush_req && (eff_cnt + pend < LANES)`.
- `o_rd` has a combinational path from `i_ready`. This path is permitted.

**Capture**
- When `pend` is 1, `acc[eff_cnt]` receives `i_rddata` and `acc_cnt` becomes `eff_cnt+1`.
- `pend` for the next cycle equals this cycle's `o_rd`.
- By construction a capture never finds `acc_cnt==LANES`. The bench asserts this as overflow-free.

**Flush**
- `i_flush` sets `flush_req`. Popping stops immediately, and any in-flight entry is still captured.
- `flush_req` clears on the `xfer` it causes.
- If `acc_cnt==0 && !pend`, `flush_req` clears with no output word.
- `i_flush` while `flush_req` is already set has no extra effect.
- A full accumulator (`acc_cnt==LANES`) under flush transfers normally, with `o_keep` all ones.

**Reset**
- The following are cleared:
  - `o_valid`=0, `o_data`=0, `o_keep`=0.
  - `acc`=0, `acc_cnt`=0.
  - `pend`=0, `flush_req`=0.
- `o_rd` is 0 while `reset` is high.
- An entry in flight when reset asserts is discarded.
- Reset mid-word discards the partial word.

## Timing

- Pop-to-capture latency: 1 cycle (`o_rd` at cycle t, data captured at the edge ending t+1).
- Latency from the last lane's capture to `o_valid`: 1 cycle when the output register is free.
- Sustained throughput: `LANES` entries per `LANES+1` cycles, given continuous `i_ready` and a non-empty FIFO.
- `o_data` and `o_keep` are stable while `o_valid && !i_ready`.
- When the output stalls, the accumulator fills to `LANES`. `o_rd` then stays low until an `xfer` frees it.
- Back-to-back words are supported: a new word loads in the same cycle the previous one is accepted.
- Simultaneous `i_flush` and capture: the capture lands first, and the flush word includes it.

## Test plan

1. **Single full word.** After reset, the FIFO holds 0x11, 0x22, 0x33, 0x44 and `i_ready`=1.
   - Required: exactly one beat, `o_data`=0x44332211, `o_keep`=0xF.
   - Required: `o_rd` asserted exactly 4 times.
2. **Backpressure.** 8 entries 0x11..0x88 with `i_ready`=0.
   - Required: first word held stable, and `o_rd` low once the second word is complete.
   - Release `i_ready`. Required: beats 0x44332211 then 0x88776655 on consecutive cycles, with no loss or duplication.
3. **Partial flush.** Entries 0xA1, 0xB2, 0xC3, then `i_flush` pulsed during the third capture.
   - Required: `o_data`=0x00C3B2A1, `o_keep`=0x7.
   - Required: no pops between the `i_flush` pulse and that beat.
4. **Empty flush.** `i_flush` with an empty accumulator and no pend.
   - Required: no beat, `flush_req` clear next cycle, popping resumes.
5. **Reset mid-word.** Capture 2 entries, assert `reset` for 1 cycle, then supply 0x01..0x04.
   - Required: all outputs 0 during reset.
   - Required: next beat `o_data`=0x04030201, `o_keep`=0xF.
6. **Empty gating.** Random `i_empty` toggling, `LANES`=4, `WIDTH`=8.
   - Required: `o_rd` never high while `i_empty`=1.
   - Required: output stream equals the FIFO order, packed lane 0 first.
